mux4_rr_sched: RTL
==================

// Module: mux4_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 4:1 bit multiplexer among 4 requesters.
//   Arbitrates req[3:0] and drives the mux selects s1:s0 plus a one-hot grant.
//   Holds each grant for up to MAX_HOLD cycles, then inserts one idle gap cycle.
//   Emits a registered copy of the selected data bit (y, y_vld) for downstream logic.
// PARAMETERS
//   MAX_HOLD  4  max consecutive grant cycles per winner; legal 1..255
//   CNT_W     8  hold-counter width; must hold MAX_HOLD
// PORTS
//   clk    in   1  clock, rising edge
//   rst    in   1  reset, asynchronous, active-high
//   req    in   4  request per source; bit n requests mux input n
//   d      in   4  data bit per source (mux inputs i0..i3)
//   gnt    out  4  one-hot grant, registered
//   s0     out  1  mux select LSB, registered
//   s1     out  1  mux select MSB, registered
//   busy   out  1  high while a grant is active (state HOLD)
//   y      out  1  registered selected data bit
//   y_vld  out  1  y is valid this cycle
// BEHAVIOUR
// - All outputs and state are registered. rst forces them immediately, not at the next edge.
// - Reset values:
//   - state=IDLE, ptr=0, hold_cnt=0;
//   - gnt=0000, {s1,s0}=00, busy=0, y=0, y_vld=0.
// - ptr is the highest-priority index. Winner = first set req bit scanning ptr, ptr+1, ...
//   with wrap 3->0 (mod 4).
// - IDLE:
//   - At an edge with req!=0: go to HOLD.
//   - gnt<=onehot(win), {s1,s0}<=win, busy<=1, hold_cnt<=1.
//   - Request-to-grant latency is 1 clock.
// - HOLD (idx = current {s1,s0}):
//   - Each edge: y<=d[idx], y_vld<=1. y lags gnt by 1 cycle.
//   - If req[idx]==0 or hold_cnt==MAX_HOLD, go to GAP:
//     - gnt<=0, busy<=0;
//     - ptr<=(idx+1) mod 4;
//     - {s1,s0} holds its value.
//   - Otherwise hold_cnt<=hold_cnt+1.
//   - A grant therefore lasts 1..MAX_HOLD cycles.
// - GAP (exactly 1 cycle):
//   - y<=d[idx], y_vld<=1. This captures the last granted cycle.
//   - At the next edge, arbitrate exactly as in IDLE using the new ptr.
//   - req!=0 -> HOLD. req==0 -> IDLE with y_vld<=0, y<=0.
// - In IDLE, y<=0 and y_vld<=0.
// - Requests arriving or dropping during GAP are only sampled at the GAP-exit edge.
// - req[idx] dropping on the same edge that hold_cnt reaches MAX_HOLD -> single transition to GAP.
// - A lone requester held high is regranted after every gap. There is no starvation of others:
//   ptr always advances past the last winner.
// - gnt is never multi-hot. gnt==0 whenever busy==0.
// - {s1,s0} only changes on a GAP/IDLE->HOLD edge. The mux select never glitches mid-grant.
// - MAX_HOLD=1: every grant is exactly 1 cycle followed by 1 gap cycle.
// - Unused state encoding -> IDLE on the next edge, with outputs cleared.
// TESTING
// 1. rst=1 mid-HOLD with req=1111 -> same cycle gnt=0000, s=00, busy=0, y_vld=0;
//    after release, first grant goes to source 0.
// 2. MAX_HOLD=4, req=0100, d=0100 -> 1 cycle later gnt=0100, s1s0=10 for 4 cycles;
//    y=1/y_vld=1 for 4 cycles lagging gnt by 1; gnt=0000 for 1 gap cycle; regrant 0100.
// 3. MAX_HOLD=4, req=1111 steady -> grant order 0,1,2,3,0, 4 cycles each,
//    1 gap cycle between grants; s1s0 sequence 00,01,10,11,00.
// 4. req=0010 granted, req[1] dropped after 2 grant cycles ->
//    GAP on the next edge (grant lasted 2 cycles); with req=1111 next, winner = source 2.
// 5. MAX_HOLD=1, req=1010 -> gnt alternates 0010, 0000, 1000, 0000, 0010, ...
// 6. Random req/d for 10k cycles vs reference model -> at most 1 gnt bit set,
//    y==d[sel] delayed 1, no grant longer than MAX_HOLD, each active requester granted within 4 grants.

Source files
------------

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 bit mux among four requesters.
// Grants are held for up to MAX_HOLD cycles, then one idle gap cycle follows.
module mux4_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       y,
  output logic       y_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic             busy_nxt, y_nxt, y_vld_nxt;
  logic [1:0]       win, cand;
  logic             win_ok;

  assign {s1, s0} = sel;

  // First requester found scanning upward from ptr, wrapping 3 -> 0.
  always_comb begin
    win    = 2'd0;
    win_ok = 1'b0;
    cand   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!win_ok && req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = sel;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    busy_nxt     = busy;
    y_nxt        = y;
    y_vld_nxt    = y_vld;
    case (state)
      IDLE: begin
        y_nxt     = 1'b0;
        y_vld_nxt = 1'b0;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
        if (win_ok) begin
          state_nxt    = HOLD;
          gnt_nxt      = 4'b0001 << win;
          sel_nxt      = win;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = CNT_W'(1);
        end
      end
      HOLD: begin
        y_nxt     = d[sel];
        y_vld_nxt = 1'b1;
        if (!req[sel] || hold_cnt >= HOLD_MAX) begin
          state_nxt = GAP;
          gnt_nxt   = 4'b0000;
          busy_nxt  = 1'b0;
          ptr_nxt   = sel + 2'd1;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (win_ok) begin
          // Select still points at the previous winner while y samples it.
          y_nxt        = d[sel];
          y_vld_nxt    = 1'b1;
          state_nxt    = HOLD;
          gnt_nxt      = 4'b0001 << win;
          sel_nxt      = win;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
          y_nxt     = 1'b0;
          y_vld_nxt = 1'b0;
          gnt_nxt   = 4'b0000;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        gnt_nxt      = 4'b0000;
        sel_nxt      = 2'd0;
        busy_nxt     = 1'b0;
        y_nxt        = 1'b0;
        y_vld_nxt    = 1'b0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
      y        <= 1'b0;
      y_vld    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      y        <= y_nxt;
      y_vld    <= y_vld_nxt;
    end
  end

endmodule
